// File: rtl/axis_packet_builder.sv
`default_nettype none
// ============================================================================
// Module      : axis_packet_builder
// Description : Buffers a raw valid/ready word stream in a small show-ahead
//               FIFO and re-emits it as AXI-Stream packets of PKT_LEN data
//               beats, with tlast on the final beat. The master port feeds
//               the memory block's s01_axis write port.
//
//               Optional feature (macro AXIS_PKT_CHKSUM_EN): each packet is
//               followed by one extra beat that carries the XOR of its
//               PKT_LEN data words. That checksum beat carries tlast instead
//               of the last data beat.
//
// Ports       : axis_aclk        - clock
//               axis_areset      - synchronous active-high reset
//               in_data/valid/ready          - raw input word handshake
//               m01_axis_tdata/tstrb/tvalid/tlast/tready - packet output
//               fifo_level       - registered FIFO occupancy (0..FIFO_DEPTH)
//               pkt_count        - registered count of completed packets
//
// Revision    : 1.0 - initial release
// ============================================================================
module axis_packet_builder #(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_LEN    = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic                    axis_aclk,
    input  logic                    axis_areset,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
    output logic                    m01_axis_tvalid,
    output logic                    m01_axis_tlast,
    input  logic                    m01_axis_tready,
    output logic [FIFO_AW:0]        fifo_level,
    output logic [15:0]             pkt_count
);

    localparam int                c_BEAT_W     = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(PKT_LEN - 1);
    localparam logic [FIFO_AW:0]  c_FULL_LEVEL = (FIFO_AW + 1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------------
    // Storage and status registers
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]    r_wr_ptr;
    logic [FIFO_AW-1:0]    r_rd_ptr;
    logic [FIFO_AW:0]      r_level;
    logic                  r_not_full;
    logic [c_BEAT_W-1:0]   r_beat;
    logic [15:0]           r_pkt_count;

    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_data_phase;
    logic                  w_data_valid;
    logic                  w_final_beat;
    logic                  w_pkt_done;
    logic [FIFO_AW:0]      w_level_next;

    assign w_empty      = (r_level == '0);
    assign w_final_beat = (r_beat == c_LAST_BEAT);

    // r_not_full resets high so the port is ready in the very first cycle
    // after reset release; the reset term keeps it low while reset is held.
    assign in_ready = r_not_full && !axis_areset;
    assign w_push   = in_valid && in_ready;

    // Data beats are only offered in the data phase; gating with reset keeps
    // the port quiet while a flush is in progress.
    assign w_data_valid = w_data_phase && !w_empty && !axis_areset;
    assign w_pop        = w_data_valid && m01_axis_tready;

    assign w_pkt_done = m01_axis_tvalid && m01_axis_tready && m01_axis_tlast;

`ifdef AXIS_PKT_CHKSUM_EN
    // ------------------------------------------------------------------------
    // Checksum FSM: DATA streams FIFO words, CSUM presents the XOR beat
    // ------------------------------------------------------------------------
    localparam logic [0:0] c_ST_DATA = 1'b0;
    localparam logic [0:0] c_ST_CSUM = 1'b1;

    logic [0:0]            r_state;
    logic [0:0]            w_state_next;
    logic [DATA_WIDTH-1:0] r_acc;

    assign w_data_phase = (r_state == c_ST_DATA);

    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            r_state <= c_ST_DATA;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_DATA: begin
                if (w_pop && w_final_beat) begin
                    w_state_next = c_ST_CSUM;
                end
            end
            c_ST_CSUM: begin
                if (m01_axis_tready) begin
                    w_state_next = c_ST_DATA;
                end
            end
            default: w_state_next = c_ST_DATA;
        endcase
    end

    // The final data word is folded in on its own handshake, so the complete
    // checksum is already in r_acc when the CSUM beat is presented.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            r_acc <= '0;
        end else if (w_pop) begin
            r_acc <= r_acc ^ r_mem[r_rd_ptr];
        end else if (r_state == c_ST_CSUM && m01_axis_tready) begin
            r_acc <= '0;
        end
    end

    always_comb begin
        m01_axis_tvalid = 1'b0;
        m01_axis_tdata  = '0;
        m01_axis_tlast  = 1'b0;
        if (w_data_valid) begin
            m01_axis_tvalid = 1'b1;
            m01_axis_tdata  = r_mem[r_rd_ptr];
        end else if (r_state == c_ST_CSUM && !axis_areset) begin
            m01_axis_tvalid = 1'b1;
            m01_axis_tdata  = r_acc;
            m01_axis_tlast  = 1'b1;
        end
    end
`else
    assign w_data_phase = 1'b1;

    always_comb begin
        m01_axis_tvalid = 1'b0;
        m01_axis_tdata  = '0;
        m01_axis_tlast  = 1'b0;
        if (w_data_valid) begin
            m01_axis_tvalid = 1'b1;
            m01_axis_tdata  = r_mem[r_rd_ptr];
            m01_axis_tlast  = w_final_beat;
        end
    end
`endif

    assign m01_axis_tstrb = {(DATA_WIDTH/8){m01_axis_tvalid}};

    // ------------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------------
    always_comb begin
        w_level_next = r_level;
        if (w_push && !w_pop) begin
            w_level_next = r_level + (FIFO_AW + 1)'(1);
        end else if (!w_push && w_pop) begin
            w_level_next = r_level - (FIFO_AW + 1)'(1);
        end
    end

    // Storage needs no reset: pointers and level define what is valid.
    always_ff @(posedge axis_aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_not_full <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            end
            r_level    <= w_level_next;
            r_not_full <= (w_level_next != c_FULL_LEVEL);
        end
    end

    // ------------------------------------------------------------------------
    // Beat and packet counters
    // ------------------------------------------------------------------------
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            r_beat      <= '0;
            r_pkt_count <= '0;
        end else begin
            if (w_pop) begin
                r_beat <= w_final_beat ? '0 : r_beat + c_BEAT_W'(1);
            end
            if (w_pkt_done) begin
                r_pkt_count <= r_pkt_count + 16'd1;
            end
        end
    end

    assign fifo_level = r_level;
    assign pkt_count  = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_axis_packet_builder.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_packet_builder
// Description : Self-checking bench for axis_packet_builder. A word-level
//               reference model turns every accepted input word into the
//               expected sequence of output beats and checks each cycle.
//               Honours AXIS_PKT_CHKSUM_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_packet_builder;

    localparam int DATA_WIDTH = 32;
    localparam int PKT_LEN    = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_AW    = 2;
`ifdef AXIS_PKT_CHKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    axis_areset;
    logic [DATA_WIDTH-1:0]   in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic                    tvalid;
    logic                    tlast;
    logic                    tready;
    logic [FIFO_AW:0]        fifo_level;
    logic [15:0]             pkt_count;

    always #5 clk = ~clk;

    axis_packet_builder #(
        .DATA_WIDTH (DATA_WIDTH),
        .PKT_LEN    (PKT_LEN),
        .FIFO_DEPTH (FIFO_DEPTH),
        .FIFO_AW    (FIFO_AW)
    ) dut (
        .axis_aclk       (clk),
        .axis_areset     (axis_areset),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .m01_axis_tdata  (tdata),
        .m01_axis_tstrb  (tstrb),
        .m01_axis_tvalid (tvalid),
        .m01_axis_tlast  (tlast),
        .m01_axis_tready (tready),
        .fifo_level      (fifo_level),
        .pkt_count       (pkt_count)
    );

    // ------------------------------------------------------------------------
    // Reference model: queue of expected output beats
    // ------------------------------------------------------------------------
    typedef struct {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
        logic                  csum;
    } beat_t;

    beat_t                 exp_q[$];
    int                    m_level;
    int                    m_cnt;
    logic [DATA_WIDTH-1:0] m_acc;
    logic [15:0]           m_pkt;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_level = 0;
        m_cnt   = 0;
        m_acc   = '0;
        m_pkt   = '0;
    endtask

    // Called at the falling edge: compare, record events, advance one cycle.
    task automatic model_cycle();
        beat_t b;
        logic  hs;
        logic  pu;
        chk("tvalid", 64'(tvalid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("tdata", 64'(tdata), 64'(exp_q[0].data));
            chk("tlast", 64'(tlast), 64'(exp_q[0].last));
            chk("tstrb", 64'(tstrb), 64'({(DATA_WIDTH/8){1'b1}}));
        end else begin
            chk("tdata_idle", 64'(tdata), 64'd0);
            chk("tlast_idle", 64'(tlast), 64'd0);
            chk("tstrb_idle", 64'(tstrb), 64'd0);
        end
        chk("fifo_level", 64'(fifo_level), 64'(m_level));
        chk("in_ready",   64'(in_ready),   64'(m_level != FIFO_DEPTH));
        chk("pkt_count",  64'(pkt_count),  64'(m_pkt));

        hs = tvalid && tready;
        pu = in_valid && in_ready;
        if (hs && exp_q.size() != 0) begin
            b = exp_q.pop_front();
            if (!b.csum) m_level--;
            if (b.last)  m_pkt++;
        end
        if (pu) begin
            m_level++;
            m_cnt++;
            m_acc  = m_acc ^ in_data;
            b.data = in_data;
            b.csum = 1'b0;
            b.last = (m_cnt == PKT_LEN) && !CSUM_EN;
            exp_q.push_back(b);
            if (m_cnt == PKT_LEN) begin
                if (CSUM_EN) begin
                    b.data = m_acc;
                    b.last = 1'b1;
                    b.csum = 1'b1;
                    exp_q.push_back(b);
                end
                m_cnt = 0;
                m_acc = '0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic v, input logic [DATA_WIDTH-1:0] d, input logic rdy);
        in_valid = v;
        in_data  = d;
        tready   = rdy;
        @(negedge clk);
        model_cycle();
    endtask

    task automatic push_word(input logic [DATA_WIDTH-1:0] d, input logic rdy);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 32 && !acc; i++) begin
            in_valid = 1'b1;
            in_data  = d;
            tready   = rdy;
            @(negedge clk);
            acc = in_ready;
            model_cycle();
        end
        in_valid = 1'b0;
        if (!acc) chk("push_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && exp_q.size() != 0; i++) begin
            step(1'b0, '0, 1'b1);
        end
        if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset(input int n);
        axis_areset = 1'b1;
        in_valid    = 1'b1;
        tready      = 1'b1;
        for (int i = 0; i < n; i++) begin
            in_data = $urandom;
            @(negedge clk);
            chk("rst_tvalid",   64'(tvalid),   64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd0);
            chk("rst_tdata",    64'(tdata),    64'd0);
            chk("rst_tstrb",    64'(tstrb),    64'd0);
            chk("rst_tlast",    64'(tlast),    64'd0);
            if (i > 0) begin
                chk("rst_level", 64'(fifo_level), 64'd0);
                chk("rst_pkt",   64'(pkt_count),  64'd0);
            end
            @(posedge clk);
            #1;
        end
        axis_areset = 1'b0;
        in_valid    = 1'b0;
        model_clear();
    endtask

    // ------------------------------------------------------------------------
    // Vector table for the basic packet
    // ------------------------------------------------------------------------
    typedef struct {
        logic                  v;
        logic [DATA_WIDTH-1:0] d;
        logic                  rdy;
        logic                  e_valid;
        logic [DATA_WIDTH-1:0] e_data;
        logic                  e_last;
        logic [FIFO_AW:0]      e_level;
    } vec_t;

    vec_t tbl [10];

    initial begin
        for (int k = 0; k < 10; k++) begin
            tbl[k].v       = (k < 8);
            tbl[k].d       = (k < 8) ? DATA_WIDTH'(k + 1) : '0;
            tbl[k].rdy     = 1'b1;
            tbl[k].e_valid = (k >= 1 && k <= 8);
            tbl[k].e_data  = (k >= 1 && k <= 8) ? DATA_WIDTH'(k) : '0;
            tbl[k].e_last  = 1'b0;
            tbl[k].e_level = (k >= 1 && k <= 8) ? 3'd1 : 3'd0;
        end
`ifdef AXIS_PKT_CHKSUM_EN
        tbl[9].e_valid = 1'b1;
        tbl[9].e_data  = 32'h08;
        tbl[9].e_last  = 1'b1;
`else
        tbl[8].e_last  = 1'b1;
`endif

        axis_areset = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        tready      = 1'b0;
        model_clear();
        #1;

        // Reset held for 3 cycles with input valid asserted
        do_reset(3);
        @(negedge clk);
        chk("ready_after_release", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Basic packet, table driven
        for (int k = 0; k < 10; k++) begin
            in_valid = tbl[k].v;
            in_data  = tbl[k].d;
            tready   = tbl[k].rdy;
            @(negedge clk);
            chk("tbl_tvalid", 64'(tvalid),     64'(tbl[k].e_valid));
            chk("tbl_tdata",  64'(tdata),      64'(tbl[k].e_data));
            chk("tbl_tlast",  64'(tlast),      64'(tbl[k].e_last));
            chk("tbl_level",  64'(fifo_level), 64'(tbl[k].e_level));
            model_cycle();
        end
        @(negedge clk);
        chk("basic_pkt_count", 64'(pkt_count), 64'd1);
        @(posedge clk);
        #1;

        // Backpressure: fill the FIFO, hold, then release
        for (int i = 0; i < 4; i++) push_word(DATA_WIDTH'(32'h21 + i), 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h25;
            tready   = 1'b0;
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready),   64'd0);
            chk("bp_level",    64'(fifo_level), 64'd4);
            chk("bp_tdata",    64'(tdata),      64'h21);
            model_cycle();
        end
        push_word(32'h25, 1'b1);
        for (int i = 0; i < 3; i++) push_word(DATA_WIDTH'(32'h26 + i), 1'b1);
        drain();

        // Simultaneous push and pop at level 2
        push_word(32'h41, 1'b0);
        push_word(32'h42, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_WIDTH'(32'h43 + i);
            tready   = 1'b1;
            @(negedge clk);
            chk("sim_level", 64'(fifo_level), 64'd2);
            model_cycle();
        end
        in_valid = 1'b0;
        tready   = 1'b0;
        @(negedge clk);
        chk("sim_level_after", 64'(fifo_level), 64'd2);
        model_cycle();
        for (int i = 0; i < 3; i++) push_word(DATA_WIDTH'(32'h46 + i), 1'b1);
        drain();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0);
        end
        drain();

        // Mid-packet reset drops the partial packet
        for (int i = 0; i < 3; i++) push_word(DATA_WIDTH'(32'h51 + i), 1'b0);
        do_reset(1);
        for (int i = 0; i < 8; i++) push_word(DATA_WIDTH'(32'h31 + i), 1'b1);
        drain();
        @(negedge clk);
        chk("midrst_pkt_count", 64'(pkt_count), 64'd1);
        chk("midrst_level",     64'(fifo_level), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
